fir_csr_master: RTL and testbench
=================================

Name: fir_csr_master

Overview:
- Memory-mapped bus initiator that drives the FIR coefficient/result CSR slave.
- Holds a local 8-entry coefficient buffer loaded by upstream logic.
- On `start`, it:
  - writes the 8 coefficients to CSR addresses 0..7,
  - optionally reads them back and compares,
  - reads the 18-bit filter result from address 8,
  - reports done/error.
- Sits between the control sequencer (or test harness) and the FIR CSR slave.

Parameters:
- NUM_COEF, 8, number of coefficient registers; CSR addresses 0..NUM_COEF-1.
- RESULT_ADDR, 8, CSR address of the filter result.
- VERIFY_EN, 1, 1 = read back and compare each coefficient after the write phase.
- TIMEOUT, 255, maximum consecutive cycles to wait for slave_ready during the write phase.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coef_we  in  1  load one coefficient into the local buffer.
- coef_idx  in  3  buffer index for coef_we.
- coef_data  in  8  coefficient value.
- start  in  1  begin a transfer sequence; sampled only when busy=0.
- slave_ready  in  1  slave accepts writes (slave status); writes are issued only while high.
- readdata  in  32  slave read data, valid exactly 1 cycle after a read strobe.
- chipselect  out  1  bus select; high on every write or read beat.
- write  out  1  write strobe, 1 cycle per beat.
- read  out  1  read strobe, 1 cycle per beat.
- address  out  4  CSR address.
- writedata  out  32  {24'b0, coef}.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  1-cycle completion pulse.
- result  out  18  captured readdata[17:0]; holds until the next capture.
- mismatch  out  1  sticky per run; a verify compare failed.
- err_idx  out  3  index of the first mismatching coefficient.
- timeout  out  1  sticky per run; write phase aborted on timeout.

Behaviour:
- **Reset:**
  - All outputs go to 0, the coefficient buffer to 0, and the FSM to IDLE.
  - Reset is asynchronous, so strobes drop immediately even mid-operation.
  - No partial state survives reset.
- **Buffer:**
  - coef_we writes coef_data into buf[coef_idx] when busy=0.
  - coef_we is ignored when busy=1.
- **Bus outputs:** registered; address, writedata, chipselect, write and read change only on a clock edge.
- **FSM states:** IDLE, WR, VRD, VWAIT, RRD, RWAIT, FIN.
- **IDLE:**
  - When start=1, clear mismatch, err_idx, timeout and the index counter, then go to WR.
  - busy goes high on the next cycle.
- **WR:**
  - Each cycle with slave_ready=1 issues one beat:
    - chipselect=1, write=1,
    - address=idx, writedata={24'b0, buf[idx]},
    - idx increments.
  - A cycle with slave_ready=0 issues no beat, holds idx and increments the wait counter.
  - The wait counter clears on every issued beat.
  - If the wait counter reaches TIMEOUT: set timeout=1 and go to FIN, skipping verify and the result read.
  - After the beat with idx=NUM_COEF-1:
    - if VERIFY_EN=1, reset idx to 0 and go to VRD,
    - otherwise go to RRD.
- **VRD:** issue chipselect=1, read=1, address=idx for 1 cycle, then go to VWAIT.
- **VWAIT:**
  - Compare readdata[7:0] with buf[idx].
  - On inequality with mismatch=0: set mismatch=1 and err_idx=idx.
  - Later mismatches do not change err_idx.
  - idx increments. Go to VRD if idx < NUM_COEF-1 before the increment, else go to RRD.
- **Verify reads:** issued without checking slave_ready, because reads are always accepted.
- **RRD:** issue chipselect=1, read=1, address=RESULT_ADDR for 1 cycle, then go to RWAIT.
- **RWAIT:** result <= readdata[17:0], then go to FIN.
- **FIN:**
  - done=1 for exactly 1 cycle.
  - busy=0 from the next cycle; return to IDLE.
  - result, mismatch, err_idx and timeout hold until the next accepted start.
- **Start while busy:** ignored.
- **start and coef_we together in IDLE:** both take effect. The buffer write lands first, so the new coefficient is used.
- **Latency:**
  - Conditions: start accepted at edge N, slave_ready held high.
  - VERIFY_EN=0: write beats at N+1..N+8, result read at N+9, capture at N+10, done at N+11.
  - VERIFY_EN=1: add 16 cycles, so done is at N+27.
- **Back-to-back:**
  - A start asserted in the FIN cycle is ignored, because busy is still 1 in that cycle.
  - The earliest new start is the cycle after FIN.
- **Protocol guarantee:** write and read are never high in the same cycle.

Test Plan:
1. **Basic run, VERIFY_EN=0, slave_ready=1:**
   - Load buf = 0x11..0x88, pulse start; the slave model returns 0x2ABCD at address 8.
   - Required: 8 consecutive write beats to addresses 0..7 with writedata 0x11..0x88, read of address 8, result=0x2ABCD, done at start+11.
2. **Backpressure:** drop slave_ready for 3 cycles after the 4th beat.
   - Required: no beats during the stall, idx holds, beat 5 is issued when ready returns, done is delayed by 3 cycles, timeout=0.
3. **Timeout:** hold slave_ready=0 with TIMEOUT=255.
   - Required: no write beats, timeout=1, done pulses after 255 waiting cycles, no read issued, result unchanged.
4. **Verify mismatch, VERIFY_EN=1:**
   - The slave model corrupts address 5 (returns 0x00 instead of 0x66) and address 7.
   - Required: mismatch=1, err_idx=5, the result read still occurs, done at start+27.
5. **Reset mid-write:** assert rst_n=0 during beat 3.
   - Required: chipselect/write drop asynchronously, all outputs and buf go to 0, FSM returns to IDLE.
   - After release, a new start writes zeros to addresses 0..7.
6. **Ignore rules:**
   - start during busy: required to have no effect.
   - coef_we during busy: required not to alter buf; the readback in the next run shows the old value.
   - start in the FIN cycle: required to be ignored.

Source files
------------

// File: rtl/fir_csr_master.sv
// Bus initiator for the FIR CSR slave: writes a local coefficient buffer to the slave,
// optionally reads it back and compares, then fetches the 18-bit filter result.
module fir_csr_master #(
    parameter int unsigned NUM_COEF    = 8,
    parameter int unsigned RESULT_ADDR = 8,
    parameter bit          VERIFY_EN   = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_coef_we,
    input  logic [2:0]  i_coef_idx,
    input  logic [7:0]  i_coef_data,
    input  logic        i_start,
    input  logic        i_slave_ready,
    input  logic [31:0] i_readdata,
    output logic        o_chipselect,
    output logic        o_write,
    output logic        o_read,
    output logic [3:0]  o_address,
    output logic [31:0] o_writedata,
    output logic        o_busy,
    output logic        o_done,
    output logic [17:0] o_result,
    output logic        o_mismatch,
    output logic [2:0]  o_err_idx,
    output logic        o_timeout
);

    localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  LAST_IDX = 3'(NUM_COEF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StVrd,
        StVwait,
        StRrd,
        StRwait,
        StFin
    } state_e;

    state_e            r_state, w_state;
    logic [2:0]        r_idx, w_idx;
    logic [WAIT_W-1:0] r_wait, w_wait;
    logic [7:0]        r_buf [NUM_COEF];
    logic              r_cs, w_cs;
    logic              r_write, w_write;
    logic              r_read, w_read;
    logic [3:0]        r_addr, w_addr;
    logic [31:0]       r_wdata, w_wdata;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic [17:0]       r_result, w_result;
    logic              r_mismatch, w_mismatch;
    logic [2:0]        r_err_idx, w_err_idx;
    logic              r_timeout, w_timeout;
    logic [7:0]        w_coef;
    logic              w_unused_rdata;

    assign w_coef         = r_buf[r_idx];
    assign w_unused_rdata = ^i_readdata[31:18];

    // Buffer is frozen while a run is in progress, including the FIN cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_coef_we && !r_busy) begin
            r_buf[i_coef_idx] <= i_coef_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_wait     <= '0;
            r_cs       <= 1'b0;
            r_write    <= 1'b0;
            r_read     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_mismatch <= 1'b0;
            r_err_idx  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_wait     <= w_wait;
            r_cs       <= w_cs;
            r_write    <= w_write;
            r_read     <= w_read;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_result   <= w_result;
            r_mismatch <= w_mismatch;
            r_err_idx  <= w_err_idx;
            r_timeout  <= w_timeout;
        end
    end

    // Strobes default low each cycle; address/writedata hold their last beat.
    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_wait     = r_wait;
        w_cs       = 1'b0;
        w_write    = 1'b0;
        w_read     = 1'b0;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_result   = r_result;
        w_mismatch = r_mismatch;
        w_err_idx  = r_err_idx;
        w_timeout  = r_timeout;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_mismatch = 1'b0;
                    w_err_idx  = '0;
                    w_timeout  = 1'b0;
                    w_idx      = '0;
                    w_wait     = '0;
                    w_busy     = 1'b1;
                    w_state    = StWr;
                end
            end
            StWr: begin
                if (i_slave_ready) begin
                    w_cs    = 1'b1;
                    w_write = 1'b1;
                    w_addr  = {1'b0, r_idx};
                    w_wdata = {24'd0, w_coef};
                    w_wait  = '0;
                    if (r_idx == LAST_IDX) begin
                        w_idx   = '0;
                        w_state = VERIFY_EN ? StVrd : StRrd;
                    end else begin
                        w_idx = r_idx + 3'd1;
                    end
                end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_state   = StFin;
                end else begin
                    w_wait = r_wait + WAIT_W'(1);
                end
            end
            StVrd: begin
                w_cs    = 1'b1;
                w_read  = 1'b1;
                w_addr  = {1'b0, r_idx};
                w_state = StVwait;
            end
            StVwait: begin
                // Only the first failing index is kept.
                if ((i_readdata[7:0] != w_coef) && !r_mismatch) begin
                    w_mismatch = 1'b1;
                    w_err_idx  = r_idx;
                end
                if (r_idx == LAST_IDX) begin
                    w_idx   = '0;
                    w_state = StRrd;
                end else begin
                    w_idx   = r_idx + 3'd1;
                    w_state = StVrd;
                end
            end
            StRrd: begin
                w_cs    = 1'b1;
                w_read  = 1'b1;
                w_addr  = 4'(RESULT_ADDR);
                w_state = StRwait;
            end
            StRwait: begin
                w_result = i_readdata[17:0];
                w_state  = StFin;
            end
            StFin: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = StIdle;
            end
            default: w_state = StIdle;
        endcase
    end

    assign o_chipselect = r_cs;
    assign o_write      = r_write;
    assign o_read       = r_read;
    assign o_address    = r_addr;
    assign o_writedata  = r_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_result     = r_result;
    assign o_mismatch   = r_mismatch;
    assign o_err_idx    = r_err_idx;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_fir_csr_master.sv
// Scoreboard bench for fir_csr_master: one instance without and one with readback verify,
// sharing a simple CSR slave model whose read data is valid on the edge after the strobe.
module tb_fir_csr_master;

    typedef struct {
        int          cyc;
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        coef_we;
    logic [2:0]  coef_idx;
    logic [7:0]  coef_data;
    logic        start0, start1;
    logic        slave_ready;
    logic [31:0] readdata0, readdata1;

    logic        cs0, wr0, rd0, busy0, done0, mism0, tmo0;
    logic [3:0]  addr0;
    logic [31:0] wdata0;
    logic [17:0] result0;
    logic [2:0]  eidx0;
    logic        cs1, wr1, rd1, busy1, done1, mism1, tmo1;
    logic [3:0]  addr1;
    logic [31:0] wdata1;
    logic [17:0] result1;
    logic [2:0]  eidx1;

    logic        sel;
    logic        m_cs, m_write, m_read, m_busy, m_done, m_mismatch, m_timeout;
    logic [3:0]  m_addr;
    logic [31:0] m_wdata;
    logic [17:0] m_result;
    logic [2:0]  m_err_idx;

    logic [7:0]  slv_mem [8];
    logic [7:0]  corrupt;
    logic [17:0] slv_res;
    logic [7:0]  tb_buf [8];

    beat_t sb[$];
    int    checks;
    int    failures;
    int    cyc;
    int    done_cyc;

    fir_csr_master #(.NUM_COEF(8), .RESULT_ADDR(8), .VERIFY_EN(1'b0), .TIMEOUT(255)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_coef_we(coef_we), .i_coef_idx(coef_idx),
        .i_coef_data(coef_data), .i_start(start0), .i_slave_ready(slave_ready),
        .i_readdata(readdata0), .o_chipselect(cs0), .o_write(wr0), .o_read(rd0),
        .o_address(addr0), .o_writedata(wdata0), .o_busy(busy0), .o_done(done0),
        .o_result(result0), .o_mismatch(mism0), .o_err_idx(eidx0), .o_timeout(tmo0)
    );

    fir_csr_master #(.NUM_COEF(8), .RESULT_ADDR(8), .VERIFY_EN(1'b1), .TIMEOUT(255)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_coef_we(coef_we), .i_coef_idx(coef_idx),
        .i_coef_data(coef_data), .i_start(start1), .i_slave_ready(slave_ready),
        .i_readdata(readdata1), .o_chipselect(cs1), .o_write(wr1), .o_read(rd1),
        .o_address(addr1), .o_writedata(wdata1), .o_busy(busy1), .o_done(done1),
        .o_result(result1), .o_mismatch(mism1), .o_err_idx(eidx1), .o_timeout(tmo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_cs       = sel ? cs1 : cs0;
    assign m_write    = sel ? wr1 : wr0;
    assign m_read     = sel ? rd1 : rd0;
    assign m_addr     = sel ? addr1 : addr0;
    assign m_wdata    = sel ? wdata1 : wdata0;
    assign m_busy     = sel ? busy1 : busy0;
    assign m_done     = sel ? done1 : done0;
    assign m_result   = sel ? result1 : result0;
    assign m_mismatch = sel ? mism1 : mism0;
    assign m_err_idx  = sel ? eidx1 : eidx0;
    assign m_timeout  = sel ? tmo1 : tmo0;

    always @(posedge clk) begin
        if (cs0 && wr0 && !addr0[3]) slv_mem[addr0[2:0]] <= wdata0[7:0];
        if (cs1 && wr1 && !addr1[3]) slv_mem[addr1[2:0]] <= wdata1[7:0];
    end

    always_comb begin
        readdata0 = '0;
        readdata1 = '0;
        if (addr0 == 4'd8) readdata0 = {14'd0, slv_res};
        else if (!addr0[3]) readdata0 = corrupt[addr0[2:0]] ? 32'd0 : {24'd0, slv_mem[addr0[2:0]]};
        if (addr1 == 4'd8) readdata1 = {14'd0, slv_res};
        else if (!addr1[3]) readdata1 = corrupt[addr1[2:0]] ? 32'd0 : {24'd0, slv_mem[addr1[2:0]]};
    end

    // Advance one clock; sample the selected DUT's bus on the falling edge.
    task automatic tick();
        beat_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (m_cs) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL bus_unexpected cyc=%0d wr=%0b rd=%0b addr=%0d required no beat",
                         cyc, m_write, m_read, m_addr);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || m_write !== e.wr || m_read !== !e.wr || m_addr !== e.addr ||
                    (e.wr && m_wdata !== e.data)) begin
                    failures++;
                    $display("FAIL bus_beat got cyc=%0d wr=%0b rd=%0b addr=%0d data=%h required cyc=%0d wr=%0b rd=%0b addr=%0d data=%h",
                             cyc, m_write, m_read, m_addr, m_wdata,
                             e.cyc, e.wr, !e.wr, e.addr, e.data);
                end
            end
        end
        if (m_done) done_cyc = cyc;
    endtask

    task automatic load_buf(input int first, input int step);
        for (int k = 0; k < 8; k++) begin
            coef_we   = 1'b1;
            coef_idx  = 3'(k);
            coef_data = 8'(first + k * step);
            tick();
            tb_buf[k] = 8'(first + k * step);
        end
        coef_we = 1'b0;
    endtask

    task automatic do_start(output int n);
        if (sel) start1 = 1'b1;
        else start0 = 1'b1;
        done_cyc = -1;
        tick();
        n = cyc;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic push_run(input int n, input bit ver, input int stall_at, input int stall_len,
                            input int nbeats, output int exp_done);
        beat_t b;
        int    base;
        for (int k = 0; k < nbeats; k++) begin
            b.cyc  = n + 1 + k + ((k >= stall_at) ? stall_len : 0);
            b.wr   = 1'b1;
            b.addr = 4'(k);
            b.data = {24'd0, tb_buf[k]};
            sb.push_back(b);
        end
        base = n + 8 + stall_len;
        if (ver) begin
            for (int k = 0; k < 8; k++) begin
                b.cyc  = base + 1 + 2 * k;
                b.wr   = 1'b0;
                b.addr = 4'(k);
                b.data = '0;
                sb.push_back(b);
            end
            base += 16;
        end
        b.cyc  = base + 1;
        b.wr   = 1'b0;
        b.addr = 4'd8;
        b.data = '0;
        sb.push_back(b);
        exp_done = base + 3;
    endtask

    task automatic wait_done(input int budget);
        int left = budget;
        while (done_cyc < 0 && left > 0) begin
            tick();
            left--;
        end
        if (done_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL done_wait no done pulse within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({cs0, wr0, rd0, addr0, wdata0, busy0, done0, result0, mism0, eidx0, tmo0} !== '0) begin
            failures++;
            $display("FAIL reset_dut0 outputs got nonzero required all zero");
        end
        checks++;
        if ({cs1, wr1, rd1, addr1, wdata1, busy1, done1, result1, mism1, eidx1, tmo1} !== '0) begin
            failures++;
            $display("FAIL reset_dut1 outputs got nonzero required all zero");
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n, exp_done;
        sel = 1'b0;
        slv_res = 18'h2ABCD;
        load_buf(8'h11, 8'h11);
        do_start(n);
        checks++;
        if (m_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%0b required=1", m_busy);
        end
        push_run(n, 1'b0, 8, 0, 8, exp_done);
        wait_done(60);
        checks++;
        if (done_cyc !== exp_done) begin
            failures++;
            $display("FAIL basic_done_cycle got=%0d required=%0d", done_cyc - n, exp_done - n);
        end
        checks++;
        if (m_result !== 18'h2ABCD || m_mismatch !== 1'b0 || m_timeout !== 1'b0) begin
            failures++;
            $display("FAIL basic_status got result=%h mism=%0b tmo=%0b required 2abcd 0 0",
                     m_result, m_mismatch, m_timeout);
        end
        checks++;
        if (m_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_end got=%0b required=0", m_busy);
        end
        tick();
        checks++;
        if (m_done !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL basic_done_width got done=%0b pending=%0d required 0 0", m_done, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int n, exp_done;
        sel = 1'b0;
        slv_res = 18'h0F00F;
        do_start(n);
        push_run(n, 1'b0, 4, 3, 8, exp_done);
        repeat (4) tick();
        slave_ready = 1'b0;
        repeat (3) tick();
        slave_ready = 1'b1;
        wait_done(60);
        checks++;
        if (done_cyc !== exp_done) begin
            failures++;
            $display("FAIL bp_done_cycle got=%0d required=%0d", done_cyc - n, exp_done - n);
        end
        checks++;
        if (m_timeout !== 1'b0 || m_result !== 18'h0F00F || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_status got tmo=%0b result=%h pending=%0d required 0 0f00f 0",
                     m_timeout, m_result, sb.size());
        end
    endtask

    task automatic test_timeout();
        int n;
        sel = 1'b0;
        slave_ready = 1'b0;
        slv_res = 18'h3FFFF;
        do_start(n);
        wait_done(400);
        slave_ready = 1'b1;
        checks++;
        if (done_cyc !== n + 256) begin
            failures++;
            $display("FAIL tmo_done_cycle got=%0d required=256", done_cyc - n);
        end
        checks++;
        if (m_timeout !== 1'b1 || m_result !== 18'h0F00F) begin
            failures++;
            $display("FAIL tmo_status got tmo=%0b result=%h required 1 0f00f", m_timeout, m_result);
        end
    endtask

    task automatic test_verify();
        int n, exp_done;
        sel = 1'b1;
        slv_res = 18'h35555;
        corrupt = 8'b1010_0000;
        do_start(n);
        push_run(n, 1'b1, 8, 0, 8, exp_done);
        wait_done(80);
        corrupt = '0;
        checks++;
        if (done_cyc !== n + 27) begin
            failures++;
            $display("FAIL verify_done_cycle got=%0d required=27", done_cyc - n);
        end
        checks++;
        if (m_mismatch !== 1'b1 || m_err_idx !== 3'd5) begin
            failures++;
            $display("FAIL verify_mismatch got mism=%0b idx=%0d required 1 5", m_mismatch, m_err_idx);
        end
        checks++;
        if (m_result !== 18'h35555 || m_timeout !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL verify_status got result=%h tmo=%0b pending=%0d required 35555 0 0",
                     m_result, m_timeout, sb.size());
        end
    endtask

    task automatic test_ignore();
        int n, exp_done;
        sel = 1'b0;
        slv_res = 18'h12345;
        load_buf(8'hA1, 1);
        do_start(n);
        push_run(n, 1'b0, 8, 0, 8, exp_done);
        tick();
        coef_we   = 1'b1;
        coef_idx  = 3'd3;
        coef_data = 8'hEE;
        start0    = 1'b1;
        tick();
        coef_we = 1'b0;
        start0  = 1'b0;
        while (cyc < n + 10) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        checks++;
        if (done_cyc !== exp_done || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_fin_start got done=%0d busy=%0b required done=%0d busy=0",
                     done_cyc - n, m_busy, exp_done - n);
        end
        do_start(n);
        push_run(n, 1'b0, 8, 0, 8, exp_done);
        wait_done(60);
        checks++;
        if (done_cyc !== exp_done || m_result !== 18'h12345 || sb.size() != 0) begin
            failures++;
            $display("FAIL ignore_rerun got done=%0d result=%h pending=%0d required %0d 12345 0",
                     done_cyc - n, m_result, sb.size(), exp_done - n);
        end
    endtask

    task automatic test_reset_mid();
        int n, exp_done;
        sel = 1'b0;
        do_start(n);
        push_run(n, 1'b0, 8, 0, 3, exp_done);
        sb.pop_back();
        repeat (3) tick();
        checks++;
        if (m_cs !== 1'b1 || m_addr !== 4'd2) begin
            failures++;
            $display("FAIL rstmid_beat3 got cs=%0b addr=%0d required 1 2", m_cs, m_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cs0, wr0, rd0, addr0, wdata0, busy0, done0, result0, mism0, eidx0, tmo0} !== '0) begin
            failures++;
            $display("FAIL rstmid_async got cs=%0b wr=%0b busy=%0b result=%h required all zero",
                     cs0, wr0, busy0, result0);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) tb_buf[k] = 8'h00;
        slv_res = 18'h00ABC;
        tick();
        do_start(n);
        push_run(n, 1'b0, 8, 0, 8, exp_done);
        wait_done(60);
        checks++;
        if (done_cyc !== exp_done || m_result !== 18'h00ABC || sb.size() != 0) begin
            failures++;
            $display("FAIL rstmid_rerun got done=%0d result=%h pending=%0d required %0d 00abc 0",
                     done_cyc - n, m_result, sb.size(), exp_done - n);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        done_cyc    = -1;
        sel         = 1'b0;
        coef_we     = 1'b0;
        coef_idx    = '0;
        coef_data   = '0;
        start0      = 1'b0;
        start1      = 1'b0;
        slave_ready = 1'b1;
        corrupt     = '0;
        slv_res     = '0;
        for (int k = 0; k < 8; k++) begin
            tb_buf[k] = '0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_verify();
        test_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
